// File: rtl/keyrom_pkg.sv
// ============================================================================
// Module   : keyrom_pkg
// Purpose  : Shared types, default parameters and key-word init function for
//            the key ROM burst reader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package keyrom_pkg;

  localparam int c_DATA_W_DEF = 16;
  localparam int c_DEPTH_DEF  = 10;
  localparam int c_ADDR_W_DEF = 4;
  localparam int c_LEN_W_DEF  = 4;

  // Multiplier that generates the fixed key words
  localparam logic [63:0] c_KEY_STEP = 64'h1234;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // Untruncated key word for index idx; callers keep the low DATA_W bits
  function automatic logic [63:0] key_word(input int unsigned idx);
    return c_KEY_STEP * 64'(idx);
  endfunction

endpackage

`default_nettype wire

// File: rtl/keyrom_array.sv
// ============================================================================
// Module   : keyrom_array
// Purpose  : Read-only DATA_W x DEPTH key store, registered read (block-ROM
//            style). Addresses at or beyond DEPTH read back as zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keyrom_array
  import keyrom_pkg::*;
#(
  parameter int DATA_W = c_DATA_W_DEF,
  parameter int DEPTH  = c_DEPTH_DEF,
  parameter int ADDR_W = c_ADDR_W_DEF
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] o_data
);

  localparam logic [ADDR_W:0] c_DEPTH_A = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] w_rom [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign w_rom[i] = DATA_W'(key_word(i));
  end

  // Registered read; out-of-range addresses return zero
  always_ff @(posedge clk) begin
    o_data <= ({1'b0, i_addr} < c_DEPTH_A) ? w_rom[i_addr] : '0;
  end

endmodule

`default_nettype wire

// File: rtl/keyrom_burst.sv
// ============================================================================
// Module   : keyrom_burst
// Purpose  : Burst reader for the key ROM with access and range checks.
//            Optional sticky lock enabled by macro KEYROM_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keyrom_burst
  import keyrom_pkg::*;
#(
  parameter int DATA_W = c_DATA_W_DEF,
  parameter int DEPTH  = c_DEPTH_DEF,
  parameter int ADDR_W = c_ADDR_W_DEF,
  parameter int LEN_W  = c_LEN_W_DEF
) (
  input  logic              mclk,
  input  logic              puc_rst,
`ifdef KEYROM_LOCK_EN
  input  logic              lock_i,
`endif
  input  logic              req_i,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              access_en,
  output logic              ready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              dout_last,
  output logic              viol,
  output logic              range_err
);

  // One bit wider than the widest operand so addr+len never wraps
  localparam int c_SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;
  localparam logic [c_SUM_W-1:0] c_DEPTH_S = c_SUM_W'(DEPTH);

  if (2 ** ADDR_W < DEPTH) begin : g_depth_chk
    $error("keyrom_burst: 2**ADDR_W must be >= DEPTH");
  end

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_cnt;
  logic                r_viol;
  logic                r_rerr;
  logic [ADDR_W-1:0]   w_rom_addr;
  logic [DATA_W-1:0]   w_rom_q;
  logic [c_SUM_W-1:0]  w_end;
  logic                w_range;
  logic                w_blocked;
  logic                w_accept;
  logic                w_valid;
  logic                w_last;
  logic                w_ready;
  logic                w_viol_nxt;
  logic                w_rerr_nxt;

`ifdef KEYROM_LOCK_EN
  logic r_lock;

  // Sticky lock, cleared only by reset
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst)     r_lock <= 1'b0;
    else if (lock_i) r_lock <= 1'b1;
  end

  assign w_blocked = !access_en || r_lock;
`else
  assign w_blocked = !access_en;
`endif

  assign w_end   = c_SUM_W'(req_addr) + c_SUM_W'(req_len);
  assign w_range = (w_end >= c_DEPTH_S);

  // State register
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next state, checks and output qualifiers
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_valid     = 1'b0;
    w_last      = 1'b0;
    w_accept    = 1'b0;
    w_viol_nxt  = 1'b0;
    w_rerr_nxt  = 1'b0;
    w_rom_addr  = r_addr;
    case (r_state)
      ST_IDLE: begin
        w_ready    = 1'b1;
        // Present the request address now so word 0 is ready next cycle
        w_rom_addr = req_addr;
        if (req_i) begin
          if (w_blocked)    w_viol_nxt = 1'b1;
          else if (w_range) w_rerr_nxt = 1'b1;
          else begin
            w_accept    = 1'b1;
            w_state_nxt = ST_BURST;
          end
        end
      end
      ST_BURST: begin
        if (w_blocked) begin
          w_viol_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_valid = 1'b1;
          if (r_cnt == '0) begin
            w_last      = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Burst address/count tracking and error pulse registers
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_addr <= '0;
      r_cnt  <= '0;
      r_viol <= 1'b0;
      r_rerr <= 1'b0;
    end else begin
      r_viol <= w_viol_nxt;
      r_rerr <= w_rerr_nxt;
      if (w_accept) begin
        r_addr <= req_addr + 1'b1;
        r_cnt  <= req_len;
      end else if (w_valid) begin
        r_addr <= r_addr + 1'b1;
        r_cnt  <= r_cnt - 1'b1;
      end
    end
  end

  keyrom_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_rom (
    .clk    (mclk),
    .i_addr (w_rom_addr),
    .o_data (w_rom_q)
  );

  assign ready      = w_ready;
  assign dout_valid = w_valid;
  assign dout_last  = w_last;
  assign dout       = w_valid ? w_rom_q : '0;
  assign viol       = r_viol;
  assign range_err  = r_rerr;

endmodule

`default_nettype wire

// File: tb/tb_keyrom_burst.sv
// ============================================================================
// Module   : tb_keyrom_burst
// Purpose  : Self-checking bench for keyrom_burst (DATA_W=16, DEPTH=10).
//            Lock scenario compiled in with KEYROM_LOCK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keyrom_burst;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 10;
  localparam int ADDR_W = 4;
  localparam int LEN_W  = 4;

  logic              mclk = 1'b0;
  logic              puc_rst;
  logic              req_i;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              access_en;
`ifdef KEYROM_LOCK_EN
  logic              lock_i;
`endif
  logic              ready;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_last;
  logic              viol;
  logic              range_err;

  int n_checks = 0;
  int n_err    = 0;
  bit model_lock = 1'b0;

  keyrom_burst #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) dut (
    .mclk       (mclk),
    .puc_rst    (puc_rst),
`ifdef KEYROM_LOCK_EN
    .lock_i     (lock_i),
`endif
    .req_i      (req_i),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .access_en  (access_en),
    .ready      (ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_last  (dout_last),
    .viol       (viol),
    .range_err  (range_err)
  );

  always #5 mclk = ~mclk;

  // Reference key word: (0x1234 * a) mod 2**16
  function automatic logic [15:0] word(input int a);
    int unsigned p;
    p = 32'h1234 * a;
    return p[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input bit e_ready, input bit e_valid,
                         input logic [15:0] e_dout, input bit e_last,
                         input bit e_viol, input bit e_rerr);
    chk({tag, ".ready"}, 32'(ready), 32'(e_ready));
    chk({tag, ".valid"}, 32'(dout_valid), 32'(e_valid));
    chk({tag, ".dout"},  32'(dout), 32'(e_dout));
    chk({tag, ".last"},  32'(dout_last), 32'(e_last));
    chk({tag, ".viol"},  32'(viol), 32'(e_viol));
    chk({tag, ".rerr"},  32'(range_err), 32'(e_rerr));
  endtask

  task automatic next_cycle();
    @(posedge mclk);
    #1;
  endtask

  task automatic sample();
    @(negedge mclk);
  endtask

  // One request; abort_at = burst cycle (1-based) in which access_en is low, 0 = none
  task automatic do_req(input int addr, input int len, input bit en,
                        input int abort_at, input string tag);
    bit blocked;
    bit aborted;
    logic [ADDR_W-1:0] a;
    logic [LEN_W-1:0]  l;
    blocked = !en || model_lock;
    aborted = 1'b0;
    a = ADDR_W'(addr);
    l = LEN_W'(len);
    next_cycle();
    req_i = 1'b1; req_addr = a; req_len = l; access_en = en;
    sample();
    chk_all({tag, ".c0"}, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    if (blocked || (addr + len >= DEPTH)) begin
      next_cycle();
      req_i = 1'b0; req_addr = ADDR_W'($urandom); req_len = LEN_W'($urandom);
      access_en = 1'b1;
      sample();
      chk_all({tag, ".err"}, 1'b1, 1'b0, 16'h0, 1'b0, blocked, !blocked);
    end else begin
      for (int k = 1; k <= len + 1; k++) begin
        next_cycle();
        req_i = 1'($urandom); req_addr = ADDR_W'($urandom); req_len = LEN_W'($urandom);
        access_en = (k != abort_at);
        sample();
        if (k == abort_at) begin
          chk_all($sformatf("%s.k%0d", tag, k), 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
          aborted = 1'b1;
          break;
        end
        chk_all($sformatf("%s.k%0d", tag, k), 1'b0, 1'b1, word(addr + k - 1),
                (k == len + 1), 1'b0, 1'b0);
      end
      next_cycle();
      req_i = 1'b0; access_en = 1'b1;
      sample();
      chk_all({tag, ".end"}, 1'b1, 1'b0, 16'h0, 1'b0, aborted, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int addr, len, ab;
    bit en;
    puc_rst = 1'b1; req_i = 1'b0; req_addr = '0; req_len = '0; access_en = 1'b1;
`ifdef KEYROM_LOCK_EN
    lock_i = 1'b0;
`endif
    repeat (2) @(posedge mclk);
    sample();
    chk_all("reset", 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    puc_rst = 1'b0;

    // Directed scenarios
    do_req(2, 2, 1'b1, 0, "dir_burst");
    do_req(8, 2, 1'b1, 0, "dir_range");
    do_req(0, 0, 1'b0, 0, "dir_viol");
    do_req(0, 9, 1'b1, 3, "dir_abort");
    do_req(9, 0, 1'b1, 0, "edge_lastword");
    do_req(0, 9, 1'b1, 0, "edge_full");
    do_req(5, 5, 1'b1, 0, "edge_range10");
    do_req(15, 15, 1'b1, 0, "edge_nowrap");

    // Reset in the middle of an addr=1, len=5 burst
    next_cycle();
    req_i = 1'b1; req_addr = 4'd1; req_len = 4'd5; access_en = 1'b1;
    sample();
    chk_all("rst_mid.c0", 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    req_i = 1'b0;
    sample();
    chk_all("rst_mid.k1", 1'b0, 1'b1, word(1), 1'b0, 1'b0, 1'b0);
    next_cycle();
    puc_rst = 1'b1;
    #1;
    chk_all("rst_mid.imm", 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    puc_rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      sample();
      chk_all($sformatf("rst_mid.after%0d", k), 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      next_cycle();
    end

    // Randomized requests
    for (int n = 0; n < 40; n++) begin
      addr = $urandom_range(0, 15);
      len  = $urandom_range(0, 6);
      en   = ($urandom_range(0, 4) != 0);
      ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len + 1) : 0;
      do_req(addr, len, en, ab, $sformatf("rnd%0d", n));
    end

`ifdef KEYROM_LOCK_EN
    next_cycle();
    lock_i = 1'b1;
    next_cycle();
    lock_i = 1'b0;
    model_lock = 1'b1;
    do_req(0, 0, 1'b1, 0, "lock_on");
    next_cycle();
    puc_rst = 1'b1;
    next_cycle();
    puc_rst = 1'b0;
    model_lock = 1'b0;
    do_req(0, 0, 1'b1, 0, "lock_cleared");
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/keyrom_burst.md
KEYROM_BURST -- requirements
Module: keyrom_burst

Interface
REQ-001 SHALL have parameter DATA_W, default 16, key word width in bits.
REQ-002 SHALL have parameter DEPTH, default 10, number of key words.
REQ-003 SHALL have parameter ADDR_W, default 4, word-address width; elaboration SHALL fail if 2**ADDR_W < DEPTH.
REQ-004 SHALL have parameter LEN_W, default 4, burst-length field width.
REQ-005 SHALL have port mclk, input, 1, sole clock; all state changes on its rising edge.
REQ-006 SHALL have port puc_rst, input, 1, reset, asynchronous, active-high.
REQ-007 SHALL have port req_i, input, 1, burst request.
REQ-008 SHALL have port req_addr, input, ADDR_W, first word address.
REQ-009 SHALL have port req_len, input, LEN_W, burst length minus one.
REQ-010 SHALL have port access_en, input, 1, key access permitted (from attestation monitor).
REQ-011 SHALL have port lock_i, input, 1, lock request; present only with KEYROM_LOCK_EN.
REQ-012 SHALL have port ready, output, 1, request accepted when req_i and ready are both high.
REQ-013 SHALL have port dout, output, DATA_W, key word.
REQ-014 SHALL have ports dout_valid and dout_last, outputs, 1 each, data qualifier and final-word marker.
REQ-015 SHALL have ports viol and range_err, outputs, 1 each, one-cycle error pulses.

Function
REQ-016 Word i SHALL hold (0x1234 * i) mod 2**DATA_W, fixed at elaboration; storage read-only.
REQ-017 FSM states SHALL be IDLE and BURST; ready SHALL be high only in IDLE.
REQ-018 Accepted request with access_en=0 (or locked) SHALL pulse viol the next cycle, emit no data, and stay in IDLE.
REQ-019 Accepted request with req_addr + req_len >= DEPTH SHALL pulse range_err the next cycle, emit no data, and stay in IDLE; this check is evaluated after REQ-018.
REQ-020 Otherwise the FSM SHALL enter BURST; the first word SHALL be valid the cycle after acceptance, followed by one word per cycle at consecutive addresses, req_len+1 words in total.
REQ-021 dout_last SHALL be high with the final word; the FSM SHALL return to IDLE on the following edge, and ready SHALL be high in that cycle.
REQ-022 Address and length SHALL be captured at acceptance; input changes during BURST SHALL be ignored.
REQ-023 access_en low during BURST SHALL abort the burst in the same cycle: dout_valid low, viol pulsed next cycle, FSM to IDLE.
REQ-024 dout SHALL be all-zero whenever dout_valid is low.
REQ-025 Address arithmetic SHALL use ADDR_W+1 bits so that the range check cannot wrap.

Reset
REQ-026 puc_rst SHALL force IDLE immediately, including mid-burst, with ready=1 and all other outputs 0; with the macro enabled, the lock flag SHALL also be cleared.
REQ-027 The burst SHALL NOT resume after reset is released.

Configuration
REQ-028 With KEYROM_LOCK_EN defined, lock_i high for one cycle SHALL set a sticky lock; thereafter every request SHALL be treated as REQ-018, and any burst in progress SHALL abort as in REQ-023, until puc_rst.
REQ-029 Without KEYROM_LOCK_EN, the lock_i port and the lock flag SHALL be absent, and behaviour SHALL be exactly as in REQ-016 to REQ-027.

Structure
REQ-030 Package keyrom_pkg SHALL hold the state enum, the default parameter constants and the init-value function (0x1234 * i).
REQ-031 Storage SHALL be sub-module keyrom_array (DATA_W x DEPTH, registered read, block-ROM style); FSM and checks SHALL be in keyrom_burst.

Verification (DATA_W=16, DEPTH=10)
REQ-032 addr=2, len=2, access_en=1 -> dout 0x2468, 0x369C, 0x48D0 on cycles +1..+3; dout_last on +3; ready high on +4.
REQ-033 addr=8, len=2 -> range_err pulse on +1; dout_valid never high; ready stays high.
REQ-034 access_en=0, addr=0, len=0 -> viol pulse on +1; dout=0x0000 throughout.
REQ-035 addr=0, len=9, access_en dropped at +3 -> words 0x0000, 0x1234 then abort; viol on +4; dout=0.
REQ-036 puc_rst asserted at +2 of an addr=1, len=5 burst -> outputs 0 and ready=1 immediately; no further valid words.
REQ-037 With KEYROM_LOCK_EN: lock_i pulse, then addr=0, len=0 -> viol; after puc_rst the same request returns 0x0000 with dout_last.
